ahb_sram_responder: RTL and testbench

//  AHB-Lite slave (responder) terminating one CoreAHB slave slot onto a single-port synchronous SRAM.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_size_decode.sv | 44 ++++
 rtl/ahb_sram_responder.sv | 197 +++++++++++++++++++
 tb/tb_ahb_sram_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite encodings (HTRANS, HSIZE, HRESP) and the state encoding
//   used by the SRAM responder's data-phase FSM.
//   No ports: imported by ahb_size_decode and ahb_sram_responder.
// ---------------------------------------------------------------------------
package ahb_pkg;

  // HTRANS encodings. Only NONSEQ and SEQ start a transfer.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings. This slot only supports up to 32-bit transfers, so the
  // fourth code is treated as an illegal size and answered with ERROR.
  localparam logic [1:0] HSIZE_BYTE    = 2'b00;
  localparam logic [1:0] HSIZE_HALF    = 2'b01;
  localparam logic [1:0] HSIZE_WORD    = 2'b10;
  localparam logic [1:0] HSIZE_ILLEGAL = 2'b11;

  // HRESP encodings (AHB-Lite only uses OKAY and ERROR).
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase FSM states of the responder.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WR,
    ST_RD,
    ST_RDV,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_size_decode.sv
// ---------------------------------------------------------------------------
// ahb_size_decode
//   Purely combinational decode of an AHB transfer size and the low address
//   bits into SRAM byte-lane enables and an alignment-error flag.
//   Ports:
//     hsize      in  2  AHB HSIZE of the address phase
//     addr_lo    in  2  HADDR[1:0] of the address phase
//     be         out 4  byte-lane enables for a 32-bit SRAM word
//     misaligned out 1  half on an odd address or word not on a 4-byte boundary
//   The illegal size code yields be=0 and misaligned=0; the top flags that
//   case separately.
// ---------------------------------------------------------------------------
module ahb_size_decode
  import ahb_pkg::*;
(
  input  logic [1:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       misaligned
);

  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        be = 4'b0001 << addr_lo;
      end
      HSIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      HSIZE_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        be         = 4'b0000;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// ---------------------------------------------------------------------------
// ahb_sram_responder
//   AHB-Lite slave terminating one CoreAHB slave slot onto a single-port
//   synchronous SRAM. The address phase is decoded and registered; the data
//   phase is sequenced by a small FSM that inserts WAIT_STATES wait cycles,
//   drives the SRAM strobes, and answers illegal, misaligned or out-of-range
//   accesses with the two-cycle ERROR response.
//   Parameters:
//     ADDR_W       SRAM word-address width (region = 2^(ADDR_W+2) bytes)
//     MAP_W        decoded window width; any set bit in
//                  haddr[MAP_W-1:ADDR_W+2] makes the access out of range
//     WAIT_STATES  extra hreadyout=0 cycles per transfer, 0..15
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     s_haddr/s_hsize/s_htrans/s_hwrite/s_hwdata/s_hready/s_hselx
//                               AHB-Lite slave inputs
//     s_hrdata/s_hresp/s_hreadyout
//                               AHB-Lite slave outputs
//     mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                               SRAM strobes, byte enables, word address, data
//     mem_rdata                 SRAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MAP_W       = 21,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_haddr,
  input  logic [1:0]        s_hsize,
  input  logic [1:0]        s_htrans,
  input  logic              s_hwrite,
  input  logic [31:0]       s_hwdata,
  input  logic              s_hready,
  input  logic              s_hselx,
  output logic [31:0]       s_hrdata,
  output logic              s_hresp,
  output logic              s_hreadyout,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Value loaded into the wait counter on accept; the WAIT state is left when
  // the counter reads zero, so loading N-1 gives exactly N wait cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_next;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic              write_q;

  logic [3:0]        dec_be;
  logic              dec_misaligned;
  logic              out_of_range;
  logic              req_active;
  logic              req_err;

  logic              capture;
  logic              open_c;
  logic              ready_c;
  logic              resp_c;
  logic              strobe_c;
  logic              we_c;
  logic              rdata_sel;

  // Address bits above the decoded window are resolved by the interconnect
  // and HTRANS[0] only distinguishes IDLE/BUSY or NONSEQ/SEQ, which this
  // slave treats alike.
  logic              unused_bits;
  assign unused_bits = ^{s_haddr[31:MAP_W]};

  ahb_size_decode u_size_decode (
    .hsize      (s_hsize),
    .addr_lo    (s_haddr[1:0]),
    .be         (dec_be),
    .misaligned (dec_misaligned)
  );

  // Address-phase decode. Every incoming request is classified here; the FSM
  // only looks at it in states where it can take a new transfer.
  assign out_of_range = |s_haddr[MAP_W-1:ADDR_W+2];
  assign req_active   = s_hselx & s_hready &
                        ((s_htrans == HTRANS_NONSEQ) | (s_htrans == HTRANS_SEQ));
  assign req_err      = (s_hsize == HSIZE_ILLEGAL) | dec_misaligned | out_of_range;

  // State, wait counter and registered address phase. Reset drops any data
  // phase in progress; the captured address fields only change on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      be_q     <= 4'b0000;
      write_q  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (capture) begin
        addr_q  <= s_haddr[ADDR_W+1:2];
        be_q    <= dec_be;
        write_q <= s_hwrite;
      end
    end
  end

  // Next-state and per-state outputs. open_c marks the states whose cycle
  // ends a data phase with hreadyout high; only there may a new address phase
  // be accepted, which is what makes back-to-back transfers dead-cycle free.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    open_c        = 1'b0;
    ready_c       = 1'b1;
    resp_c        = 1'b0;
    strobe_c      = 1'b0;
    we_c          = 1'b0;
    rdata_sel     = 1'b0;

    case (state)
      ST_IDLE: begin
        open_c = 1'b1;
      end
      ST_WAIT: begin
        ready_c = 1'b0;
        if (wait_cnt == 4'd0) begin
          state_next = write_q ? ST_WR : ST_RD;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_WR: begin
        strobe_c = 1'b1;
        we_c     = 1'b1;
        open_c   = 1'b1;
      end
      ST_RD: begin
        ready_c    = 1'b0;
        strobe_c   = 1'b1;
        state_next = ST_RDV;
      end
      ST_RDV: begin
        rdata_sel = 1'b1;
        open_c    = 1'b1;
      end
      ST_ERR1: begin
        ready_c    = 1'b0;
        resp_c     = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        resp_c = 1'b1;
        open_c = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (open_c) begin
      state_next = ST_IDLE;
      if (req_active) begin
        capture = 1'b1;
        if (req_err) begin
          state_next = ST_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_next = s_hwrite ? ST_WR : ST_RD;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = WAIT_LOAD;
        end
      end
    end
  end

  // Outputs are forced to their idle values while reset is asserted so that
  // an aborted data phase can never strobe the SRAM or stall the bus.
  assign s_hreadyout = rst | ready_c;
  assign s_hresp     = (~rst & resp_c) ? HRESP_ERROR : HRESP_OKAY;
  assign s_hrdata    = (~rst & rdata_sel) ? mem_rdata : 32'h0000_0000;
  assign mem_en      = ~rst & strobe_c;
  assign mem_we      = ~rst & we_c;
  assign mem_be      = mem_en ? be_q : 4'b0000;
  assign mem_addr    = addr_q;
  assign mem_wdata   = s_hwdata;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_responder
//   Two responders on one AHB-Lite bus: slot A with one wait state, slot B
//   with none. Each has its own SRAM model. A driver issues pipelined
//   transfers and pushes the expected response from a byte-level reference
//   memory into a queue; a monitor measures every data phase and compares.
// ---------------------------------------------------------------------------
module tb_ahb_sram_responder;
  import ahb_pkg::*;

  localparam int ADDR_W = 12;
  localparam int MAP_W  = 21;
  localparam int REGION = 1 << (ADDR_W + 2);
  localparam int WORDS  = 1 << ADDR_W;
  localparam int WS_A   = 1;
  localparam int WS_B   = 0;

  typedef struct {
    int                cycles;
    logic              resp;
    logic [31:0]       rdata;
    int                strobes;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] waddr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] haddr;
  logic [1:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hsel;
  logic        slot;
  logic        hsel_a;
  logic        hsel_b;

  logic [31:0]       hrdata_a, hrdata_b;
  logic              hresp_a, hresp_b;
  logic              hreadyout_a, hreadyout_b;
  logic              mem_en_a, mem_en_b;
  logic              mem_we_a, mem_we_b;
  logic [3:0]        mem_be_a, mem_be_b;
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [31:0]       mem_wdata_a, mem_wdata_b;
  logic [31:0]       mem_rdata_a = 32'h0;
  logic [31:0]       mem_rdata_b = 32'h0;

  logic              bus_hready;
  logic              bus_hresp;
  logic [31:0]       bus_hrdata;
  logic              bus_mem_en;
  logic              bus_mem_we;
  logic [3:0]        bus_mem_be;
  logic [ADDR_W-1:0] bus_mem_addr;

  assign hsel_a       = hsel && (slot == 1'b0);
  assign hsel_b       = hsel && (slot == 1'b1);
  assign bus_hready   = slot ? hreadyout_b : hreadyout_a;
  assign bus_hresp    = slot ? hresp_b     : hresp_a;
  assign bus_hrdata   = slot ? hrdata_b    : hrdata_a;
  assign bus_mem_en   = slot ? mem_en_b    : mem_en_a;
  assign bus_mem_we   = slot ? mem_we_b    : mem_we_a;
  assign bus_mem_be   = slot ? mem_be_b    : mem_be_a;
  assign bus_mem_addr = slot ? mem_addr_b  : mem_addr_a;

  ahb_sram_responder #(.ADDR_W(ADDR_W), .MAP_W(MAP_W), .WAIT_STATES(WS_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .s_haddr(haddr), .s_hsize(hsize), .s_htrans(htrans), .s_hwrite(hwrite),
    .s_hwdata(hwdata), .s_hready(bus_hready), .s_hselx(hsel_a),
    .s_hrdata(hrdata_a), .s_hresp(hresp_a), .s_hreadyout(hreadyout_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_be(mem_be_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  ahb_sram_responder #(.ADDR_W(ADDR_W), .MAP_W(MAP_W), .WAIT_STATES(WS_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_haddr(haddr), .s_hsize(hsize), .s_htrans(htrans), .s_hwrite(hwrite),
    .s_hwdata(hwdata), .s_hready(bus_hready), .s_hselx(hsel_b),
    .s_hrdata(hrdata_b), .s_hresp(hresp_b), .s_hreadyout(hreadyout_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Synchronous single-port SRAM models with byte-lane writes.
  logic [31:0] sram_a [WORDS] = '{default: 32'h0};
  logic [31:0] sram_b [WORDS] = '{default: 32'h0};

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) begin
        for (int i = 0; i < 4; i++)
          if (mem_be_a[i]) sram_a[mem_addr_a][8*i +: 8] <= mem_wdata_a[8*i +: 8];
      end else begin
        mem_rdata_a <= sram_a[mem_addr_a];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_en_b) begin
      if (mem_we_b) begin
        for (int i = 0; i < 4; i++)
          if (mem_be_b[i]) sram_b[mem_addr_b][8*i +: 8] <= mem_wdata_b[8*i +: 8];
      end else begin
        mem_rdata_b <= sram_b[mem_addr_b];
      end
    end
  end

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];
  logic [7:0]  ref_mem [2][REGION];
  logic [31:0] pend_wdata;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: classify the transfer from the addressing rules and
  // read/update a byte-addressed image of each slot's region.
  task automatic predict(input logic s, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
    exp_t        e;
    int unsigned a;
    int          nbytes, off, base, lane0, si, ws;
    bit          err;
    si     = s ? 1 : 0;
    ws     = s ? WS_B : WS_A;
    a      = addr;
    nbytes = 1 << size;
    err    = (size == 2'd3) || ((a % nbytes) != 0) || ((a % (32'd1 << MAP_W)) >= REGION);
    off    = int'(a % REGION);
    base   = off - (off % 4);
    lane0  = off % 4;
    e.cycles  = 2;
    e.resp    = err;
    e.rdata   = 32'h0;
    e.strobes = 0;
    e.we      = wr;
    e.be      = 4'b0000;
    e.waddr   = '0;
    if (!err) begin
      e.cycles  = wr ? ws + 1 : ws + 2;
      e.strobes = 1;
      e.waddr   = ADDR_W'(off / 4);
      for (int i = 0; i < 4; i++) begin
        if (i >= lane0 && i < lane0 + nbytes) begin
          e.be[i] = 1'b1;
          if (wr) ref_mem[si][base + i] = wdata[8*i +: 8];
        end
      end
      if (!wr)
        for (int i = 0; i < 4; i++) e.rdata[8*i +: 8] = ref_mem[si][base + i];
    end
    sb_q.push_back(e);
  endtask

  // Waits for the edge at which the current address phase is taken.
  task automatic wait_accept();
    int budget = 50;
    @(negedge clk);
    while (!bus_hready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL hready_timeout: got hready=0 for 50 cycles, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  // kind 0: unselected, 1: selected IDLE, 2: selected BUSY.
  task automatic apply_idle(input int kind);
    hsel   = (kind != 0);
    htrans = (kind == 2) ? HTRANS_BUSY : ((kind == 0) ? 2'($urandom_range(0, 3)) : HTRANS_IDLE);
    haddr  = $urandom;
    hsize  = 2'($urandom_range(0, 3));
    hwrite = 1'($urandom_range(0, 1));
    hwdata = pend_wdata;
    wait_accept();
  endtask

  task automatic apply_stimulus(input logic s, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata,
                                input logic [1:0] trans, input bit do_predict);
    if (s != slot) begin
      apply_idle(0);
      slot = s;
    end
    hsel   = 1'b1;
    haddr  = addr;
    hsize  = size;
    hwrite = wr;
    htrans = trans;
    hwdata = pend_wdata;
    wait_accept();
    if (do_predict) predict(s, wr, addr, size, wdata);
    pend_wdata = wdata;
  endtask

  // Monitor: follows each data phase from its accept edge to the first
  // cycle with hready high, then compares against the queued expectation.
  bit                dp_pending = 0;
  bit                dp_active  = 0;
  int                dp_cycles, dp_strobes;
  logic              dp_we;
  logic [3:0]        dp_be;
  logic [ADDR_W-1:0] dp_addr;
  exp_t              mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        dp_pending = 0;
        dp_active  = 0;
      end else begin
        if (dp_pending) begin
          dp_active  = 1;
          dp_pending = 0;
          dp_cycles  = 0;
          dp_strobes = 0;
          dp_we      = 1'b0;
          dp_be      = 4'b0000;
          dp_addr    = '0;
        end
        if (dp_active) begin
          dp_cycles++;
          if (bus_mem_en) begin
            dp_strobes++;
            dp_we   = bus_mem_we;
            dp_be   = bus_mem_be;
            dp_addr = bus_mem_addr;
          end
          if (bus_hready) begin
            if (sb_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL unexpected_phase: got a completed data phase, expected none");
            end else begin
              mon_e = sb_q.pop_front();
              check_output("hresp", 64'(bus_hresp), 64'(mon_e.resp));
              check_output("hrdata", 64'(bus_hrdata), 64'(mon_e.rdata));
              check_output("phase_cycles", 64'(dp_cycles), 64'(mon_e.cycles));
              check_output("mem_strobes", 64'(dp_strobes), 64'(mon_e.strobes));
              if (mon_e.strobes != 0)
                check_output("mem_we_be_addr", 64'({dp_we, dp_be, dp_addr}),
                             64'({mon_e.we, mon_e.be, mon_e.waddr}));
            end
            dp_active = 0;
          end
        end else begin
          check_output("idle_bus", 64'({bus_hready, bus_hresp, bus_hrdata, mem_en_a, mem_en_b}),
                       64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0}));
        end
        if (hsel && bus_hready && htrans[1]) dp_pending = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    int          word, lane, r;
    rst        = 1'b1;
    hsel       = 1'b0;
    htrans     = HTRANS_IDLE;
    haddr      = 32'h0;
    hsize      = 2'b00;
    hwrite     = 1'b0;
    hwdata     = 32'h0;
    slot       = 1'b0;
    pend_wdata = 32'h0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < REGION; i++) ref_mem[s][i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_a", 64'({hreadyout_a, hresp_a, hrdata_a, mem_en_a, mem_we_a, mem_be_a}),
                 64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000}));
    check_output("reset_b", 64'({hreadyout_b, hresp_b, hrdata_b, mem_en_b, mem_we_b, mem_be_b}),
                 64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'b0000}));
    @(posedge clk);
    #1 rst = 1'b0;

    // Slot A, one wait state: word write/read, byte and half merges.
    apply_stimulus(0, 1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 1, 32'h13, HSIZE_BYTE, 32'hAA00_0000, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 1, 32'h16, HSIZE_HALF, 32'h1234_0000, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h14, HSIZE_WORD, 32'h0, HTRANS_SEQ, 1);
    // Error responses: misaligned, out of window, illegal size, misaligned write.
    apply_stimulus(0, 0, 32'h02, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h4000, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h20, HSIZE_ILLEGAL, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 1, 32'h11, HSIZE_HALF, 32'h5555_5555, HTRANS_NONSEQ, 1);
    apply_stimulus(0, 0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    // Bits above the decoded window are not part of the range check.
    apply_stimulus(0, 0, 32'hFFE0_0010, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_idle(0);

    // Slot B, zero wait states: back-to-back write, read, write, read.
    apply_stimulus(1, 1, 32'h40, HSIZE_WORD, 32'h1122_3344, HTRANS_NONSEQ, 1);
    apply_stimulus(1, 0, 32'h40, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_stimulus(1, 1, 32'h44, HSIZE_WORD, 32'h5566_7788, HTRANS_NONSEQ, 1);
    apply_stimulus(1, 0, 32'h44, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);
    apply_idle(0);

    // Reset in the wait cycle of a slot A write: the write must never land.
    apply_stimulus(0, 1, 32'h10, HSIZE_WORD, 32'hCAFE_F00D, HTRANS_NONSEQ, 0);
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    hwdata = 32'hCAFE_F00D;
    rst    = 1'b1;
    @(negedge clk);
    check_output("abort_no_strobe", 64'(mem_en_a), 64'(1'b0));
    @(posedge clk);
    #1 rst = 1'b0;
    pend_wdata = 32'h0;
    @(negedge clk);
    check_output("abort_idle", 64'({hreadyout_a, hresp_a, mem_en_a}), 64'(3'b100));
    @(posedge clk);
    #1;
    apply_stimulus(0, 0, 32'h10, HSIZE_WORD, 32'h0, HTRANS_NONSEQ, 1);

    // Randomized mix across both slots.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        apply_idle($urandom_range(0, 2));
      end else begin
        size = ($urandom_range(0, 15) == 0) ? HSIZE_ILLEGAL : 2'($urandom_range(0, 2));
        word = $urandom_range(0, 15);
        lane = $urandom_range(0, 3);
        if (size != HSIZE_ILLEGAL && $urandom_range(0, 4) != 0)
          lane = lane - (lane % (1 << size));
        addr = 32'(word * 4 + lane);
        if ($urandom_range(0, 9) == 0)
          addr = addr | (32'd1 << $urandom_range(ADDR_W + 2, MAP_W - 1));
        if ($urandom_range(0, 4) == 0)
          addr[31:MAP_W] = 11'($urandom_range(0, 2047));
        apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, size,
                       $urandom, $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ, 1);
      end
    end

    apply_idle(0);
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
    check_output("scoreboard_drain", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
